nt_level_scheduler: RTL
=======================

Name: nt_level_scheduler

Overview:
- Sequences one neurotransmitter level resource (inc/dec/fast/setval counter).
- Collects regulator requests between slow scheduler ticks, resolves conflicts and enforces a cooldown after each step.
- After prolonged inactivity, drifts the level back toward its resting value.
- Sits between a regulator and its level resource inside each nt_*_system.

Parameters:
- N, 7, width of level value
- DEFAULT_VAL, 96, resting level targeted in RECOVER
- PRESCALE, 16, clk cycles per tick (≥2)
- COOLDOWN, 2, ticks spent in COOL after an issued step (≥1)
- IDLE_TIMEOUT, 8, consecutive idle ticks before entering RECOVER (≥1)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- req_inc  input  1  regulator increment request
- req_dec  input  1  regulator decrement request
- req_fast  input  1  regulator fast-step request
- req_set  input  1  force level to resource SET_VAL
- value  input  N  current level from resource
- inc  output  1  one-cycle increment pulse to resource
- dec  output  1  one-cycle decrement pulse to resource
- fast  output  1  fast qualifier, valid with inc/dec
- setval  output  1  one-cycle set pulse to resource
- state  output  2  IDLE=0, COOL=1, RECOVER=2
- busy  output  1  high when state≠IDLE

Behaviour:
- Reset: state IDLE; prescaler, cooldown, idle counters and pending flags 0; all outputs 0.
- Prescaler counts 0..PRESCALE-1 and wraps. tick=1 when count==PRESCALE-1.
- Pending flags p_inc, p_dec, p_fast, p_set are sticky-OR of the req_* inputs. A request on the tick cycle itself is included in that tick's decision.
- All pending flags clear on every tick where they are evaluated. Exception: in COOL, p_inc/p_dec/p_fast persist until the first tick after COOL exits.
- Outputs are registered and pulse for exactly one cycle, the cycle after the deciding tick. At most one of inc/dec/setval is high. fast is high only together with inc or dec.
- Decision at tick, priority order:
  - p_set → setval.
  - p_inc xor p_dec → inc or dec, with fast=p_fast.
  - p_inc and p_dec both set → conflict; flags discarded, no pulse, treated as idle.
  - No flags set → idle.
- IDLE, at tick:
  - setval or step issued → COOL, cooldown counter=0, idle counter=0.
  - Idle decision → idle counter +1. When it reaches IDLE_TIMEOUT → RECOVER, idle counter=0.
- COOL, at tick:
  - p_set still issues setval immediately and restarts the cooldown.
  - Otherwise cooldown counter +1. At COOLDOWN → IDLE.
- RECOVER, at tick:
  - Any non-conflicting request → served as in IDLE, then → COOL.
  - Otherwise value>DEFAULT_VAL → dec (fast=0); value<DEFAULT_VAL → inc (fast=0); value==DEFAULT_VAL → IDLE with no pulse.
- Counter widths: $clog2 of their limit +1. Counters never wrap past their limit.
- rst_n asserted mid-pulse forces outputs to 0 immediately (async).

Optional Feature:
- Macro: NT_SCHED_STATS_EN.
- Defined: adds output dbg_pulse_cnt[7:0]. It counts issued inc/dec/setval pulses, saturates at 255 and resets to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package nt_sched_pkg: state encodings (ST_IDLE, ST_COOL, ST_RECOVER) and the 2-bit state width constant.
- Sub-module nt_tick_prescaler (parameter PRESCALE, outputs tick), reusable by other nt_* systems.
- FSM, pending flags and output registers live in the top module.

Test Plan:
All cases use PRESCALE=4, COOLDOWN=2, IDLE_TIMEOUT=3, DEFAULT_VAL=96.
- Reset, no requests → all outputs 0; after 3 ticks state=2. With value=100 → dec pulse one cycle after each tick. At value=96 → state=0.
- req_inc pulse at cycle 1 → inc=1 for one cycle after the tick at cycle 3, fast=0; state=1 for 2 ticks, then 0.
- req_inc and req_dec in the same window → no pulse, state stays 0, idle counter increments.
- req_dec+req_fast in window, then req_set during COOL → first dec with fast=1, then setval at the next tick; COOL restarts.
- In RECOVER with value=90 and req_dec arriving → dec issued (not inc), state=1.
- With NT_SCHED_STATS_EN, 300 issued pulses → dbg_pulse_cnt=255.

Source files
------------

// File: rtl/nt_level_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// nt_sched_pkg
// Shared definitions for the neurotransmitter level scheduler family.
//   - state_t    : scheduler state encoding, also driven out on the debug
//                  'state' port (IDLE=0, COOL=1, RECOVER=2).
//   - decision_t : outcome of resolving the pending request flags at a tick.
//   - resolve()  : request priority: set > (inc xor dec) > nothing.
//                  inc and dec together is a conflict and resolves to nothing.
// -----------------------------------------------------------------------------
package nt_sched_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_COOL    = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DEC_NONE = 2'd0,
        DEC_SET  = 2'd1,
        DEC_INC  = 2'd2,
        DEC_DEC  = 2'd3
    } decision_t;

    function automatic decision_t resolve(input logic e_set,
                                          input logic e_inc,
                                          input logic e_dec);
        decision_t d;
        if (e_set) begin
            d = DEC_SET;
        end else if (e_inc && !e_dec) begin
            d = DEC_INC;
        end else if (e_dec && !e_inc) begin
            d = DEC_DEC;
        end else begin
            d = DEC_NONE;
        end
        return d;
    endfunction

endpackage

// File: rtl/nt_level_scheduler_prescaler.sv
// -----------------------------------------------------------------------------
// nt_tick_prescaler
// Free-running counter 0..PRESCALE-1 that produces the slow scheduler tick.
// tick is combinational and high during the cycle in which the count equals
// PRESCALE-1, so logic clocked on that edge sees tick and the wrap together.
//
// Parameters:
//   PRESCALE : clk cycles per tick (>= 2)
// Ports:
//   clk   in  : clock
//   rst_n in  : asynchronous active-low reset, clears the count
//   tick  out : one-cycle strobe every PRESCALE cycles
// -----------------------------------------------------------------------------
module nt_tick_prescaler #(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nt_level_scheduler.sv
// -----------------------------------------------------------------------------
// nt_level_scheduler
// Sequences one neurotransmitter level resource. Regulator requests are
// collected into sticky pending flags between slow ticks, resolved at the tick
// into at most one registered one-cycle pulse (inc / dec / setval, with fast
// qualifying inc/dec), followed by a cooldown. After IDLE_TIMEOUT idle ticks
// the level is drifted back toward DEFAULT_VAL one step per tick.
//
// Optional build macro NT_SCHED_STATS_EN adds dbg_pulse_cnt, a saturating
// count of issued inc/dec/setval pulses.
//
// Parameters:
//   N            : level width
//   DEFAULT_VAL  : resting level targeted while recovering
//   PRESCALE     : clk cycles per tick (>= 2)
//   COOLDOWN     : ticks spent cooling after an issued step (>= 1)
//   IDLE_TIMEOUT : consecutive idle ticks before recovering (>= 1)
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_inc/dec/fast/set   : regulator requests (any cycle, sticky until tick)
//   value[N-1:0]           : current level from the resource
//   inc, dec, fast, setval : one-cycle pulses to the resource
//   state[1:0]             : IDLE=0, COOL=1, RECOVER=2
//   busy                   : state != IDLE
//   dbg_pulse_cnt[7:0]     : (NT_SCHED_STATS_EN only) issued pulse count
// -----------------------------------------------------------------------------
module nt_level_scheduler
    import nt_sched_pkg::*;
#(
    parameter int N            = 7,
    parameter int DEFAULT_VAL  = 96,
    parameter int PRESCALE     = 16,
    parameter int COOLDOWN     = 2,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_inc,
    input  logic             req_dec,
    input  logic             req_fast,
    input  logic             req_set,
    input  logic [N-1:0]     value,
    output logic             inc,
    output logic             dec,
    output logic             fast,
    output logic             setval,
    output logic [STATE_W-1:0] state,
    output logic             busy
`ifdef NT_SCHED_STATS_EN
    ,
    output logic [7:0]       dbg_pulse_cnt
`endif
);

    localparam int CD_W = $clog2(COOLDOWN) + 1;
    localparam int IT_W = $clog2(IDLE_TIMEOUT) + 1;
    localparam logic [N-1:0]    DEF_V   = N'(DEFAULT_VAL);
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN - 1);
    localparam logic [IT_W-1:0] IT_LAST = IT_W'(IDLE_TIMEOUT - 1);

    // Tick generator
    logic w_tick;

    nt_tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (w_tick)
    );

    // State and counters
    state_t          r_state,    w_state_nxt;
    logic [CD_W-1:0] r_cd_cnt,   w_cd_nxt;
    logic [IT_W-1:0] r_idle_cnt, w_idle_nxt;

    // Pending request flags
    logic r_p_inc,  w_p_inc_nxt;
    logic r_p_dec,  w_p_dec_nxt;
    logic r_p_fast, w_p_fast_nxt;
    logic r_p_set,  w_p_set_nxt;

    // Output registers
    logic r_inc,    w_inc_nxt;
    logic r_dec,    w_dec_nxt;
    logic r_fast,   w_fast_nxt;
    logic r_setval, w_setval_nxt;

    // Effective flags include a request arriving on the tick cycle itself.
    logic      w_e_inc, w_e_dec, w_e_fast, w_e_set;
    decision_t w_decision;

    assign w_e_inc    = r_p_inc  | req_inc;
    assign w_e_dec    = r_p_dec  | req_dec;
    assign w_e_fast   = r_p_fast | req_fast;
    assign w_e_set    = r_p_set  | req_set;
    assign w_decision = resolve(w_e_set, w_e_inc, w_e_dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cd_cnt   <= '0;
            r_idle_cnt <= '0;
            r_p_inc    <= 1'b0;
            r_p_dec    <= 1'b0;
            r_p_fast   <= 1'b0;
            r_p_set    <= 1'b0;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_fast     <= 1'b0;
            r_setval   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cd_cnt   <= w_cd_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_p_inc    <= w_p_inc_nxt;
            r_p_dec    <= w_p_dec_nxt;
            r_p_fast   <= w_p_fast_nxt;
            r_p_set    <= w_p_set_nxt;
            r_inc      <= w_inc_nxt;
            r_dec      <= w_dec_nxt;
            r_fast     <= w_fast_nxt;
            r_setval   <= w_setval_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cd_nxt     = r_cd_cnt;
        w_idle_nxt   = r_idle_cnt;
        // Between ticks the flags simply accumulate.
        w_p_inc_nxt  = w_e_inc;
        w_p_dec_nxt  = w_e_dec;
        w_p_fast_nxt = w_e_fast;
        w_p_set_nxt  = w_e_set;
        w_inc_nxt    = 1'b0;
        w_dec_nxt    = 1'b0;
        w_fast_nxt   = 1'b0;
        w_setval_nxt = 1'b0;

        if (w_tick) begin
            case (r_state)
                ST_IDLE, ST_RECOVER: begin
                    w_p_inc_nxt  = 1'b0;
                    w_p_dec_nxt  = 1'b0;
                    w_p_fast_nxt = 1'b0;
                    w_p_set_nxt  = 1'b0;
                    case (w_decision)
                        DEC_SET: begin
                            w_setval_nxt = 1'b1;
                            w_state_nxt  = ST_COOL;
                            w_cd_nxt     = '0;
                            w_idle_nxt   = '0;
                        end
                        DEC_INC: begin
                            w_inc_nxt   = 1'b1;
                            w_fast_nxt  = w_e_fast;
                            w_state_nxt = ST_COOL;
                            w_cd_nxt    = '0;
                            w_idle_nxt  = '0;
                        end
                        DEC_DEC: begin
                            w_dec_nxt   = 1'b1;
                            w_fast_nxt  = w_e_fast;
                            w_state_nxt = ST_COOL;
                            w_cd_nxt    = '0;
                            w_idle_nxt  = '0;
                        end
                        default: begin
                            if (r_state == ST_IDLE) begin
                                // Idle or conflicting tick counts toward timeout.
                                if (r_idle_cnt == IT_LAST) begin
                                    w_state_nxt = ST_RECOVER;
                                    w_idle_nxt  = '0;
                                end else begin
                                    w_idle_nxt = r_idle_cnt + IT_W'(1);
                                end
                            end else begin
                                // Recover: single slow step toward rest level.
                                if (value > DEF_V) begin
                                    w_dec_nxt = 1'b1;
                                end else if (value < DEF_V) begin
                                    w_inc_nxt = 1'b1;
                                end else begin
                                    w_state_nxt = ST_IDLE;
                                    w_idle_nxt  = '0;
                                end
                            end
                        end
                    endcase
                end
                ST_COOL: begin
                    // Only set is served while cooling; inc/dec/fast stay pending
                    // and are evaluated at the first tick after cooling ends.
                    w_p_set_nxt = 1'b0;
                    if (w_e_set) begin
                        w_setval_nxt = 1'b1;
                        w_cd_nxt     = '0;
                    end else if (r_cd_cnt == CD_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cd_nxt    = '0;
                    end else begin
                        w_cd_nxt = r_cd_cnt + CD_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cd_nxt    = '0;
                    w_idle_nxt  = '0;
                end
            endcase
        end
    end

    assign inc    = r_inc;
    assign dec    = r_dec;
    assign fast   = r_fast;
    assign setval = r_setval;
    assign state  = r_state;
    assign busy   = (r_state != ST_IDLE);

`ifdef NT_SCHED_STATS_EN
    logic [7:0] r_pulse_cnt;
    logic       w_issue;

    assign w_issue = w_inc_nxt | w_dec_nxt | w_setval_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse_cnt <= '0;
        end else if (w_issue && (r_pulse_cnt != 8'hFF)) begin
            r_pulse_cnt <= r_pulse_cnt + 8'd1;
        end
    end

    assign dbg_pulse_cnt = r_pulse_cnt;
`endif

endmodule
